nibble_parity_rx: RTL and testbench
===================================

// Module: nibble_parity_rx
// PURPOSE
//  Serial receiver and checker for the framed nibble link. The transmit end sends the 4-bit
//  word with its XOR parity bit; this block deframes one bit per clock and rebuilds the word.
//  It recomputes the AND/OR/XOR reductions and flags parity, framing and overrun errors.
//  Results go to the downstream consumer through a 1-deep valid/ready output buffer.
// PARAMETERS
//  DATA_W      4   data bits per frame (>=2); reductions span all DATA_W bits
//  PARITY_ODD  0   0: even parity (^{data,par}==0); 1: odd parity (^{data,par}==1)
//  CNT_W       8   error counter width (used only with NIBBLE_PARITY_RX_ERRCNT_EN)
// PORTS
//  clk            in   1       rising-edge clock
//  areset_n       in   1       asynchronous active-low reset
//  rx_bit         in   1       serial line, idle high, one bit per clk
//  out_ready      in   1       consumer accepts out_data when out_valid&&out_ready
//  out_valid      out  1       buffered frame available
//  out_data       out  DATA_W  received word (first data bit on line = bit 0)
//  out_and        out  1       &out_data
//  out_or         out  1       |out_data
//  out_par_err    out  1       parity mismatch for buffered frame
//  out_frame_err  out  1       stop bit sampled 0 for buffered frame
//  overrun        out  1       1-cycle pulse: completed frame dropped, buffer full
//  err_clr        in   1       [ERRCNT_EN only] synchronous clear of err_count
//  err_count      out  CNT_W   [ERRCNT_EN only] saturating error-frame count
// BEHAVIOUR
//  Reset (areset_n=0, async): FSM=IDLE, bit index=0, shift reg=0, all outputs 0.
//  Frame format: start(0), DATA_W data bits LSB first, parity, stop(1). Length is DATA_W+3 clk.
//  FSM, one sample per clk:
//   IDLE:   rx_bit==0 -> DATA, idx=0; else stay.
//   DATA:   shift[idx]<=rx_bit; idx==DATA_W-1 -> PARITY, else idx++.
//   PARITY: capture par bit -> STOP.
//   STOP:   sample stop bit, frame complete -> IDLE. The next start bit is legal the very next clk.
//  No start-bit glitch filter. No resync inside a frame. A bad stop bit still returns to IDLE.
//  Checks at completion: par_err = (^shift)^par^PARITY_ODD; frame_err = ~stop.
//  Output buffer: on completion, load the buffer if !out_valid or (out_valid&&out_ready)
//   in the same clk. This loads out_data, out_and, out_or, out_par_err and out_frame_err,
//   and out_valid=1 from the following clk.
//   Latency: stop bit sampled at edge k -> out_valid high after edge k.
//  Frames with par_err/frame_err are still delivered, with their flags set.
//  Completion while out_valid&&!out_ready: the frame is dropped, the buffer is unchanged,
//   and overrun pulses for 1 clk.
//  Accept without a new completion: out_valid->0. Data and flags hold their last value.
//  Outputs are registered only. No combinational path from rx_bit or out_ready to outputs.
//  Reset mid-frame aborts the frame. No partial output. Rx restarts at IDLE.
// CONFIGURATION
//  `define NIBBLE_PARITY_RX_ERRCNT_EN: adds err_clr/err_count.
//   The counter increments by 1 on each completion with par_err|frame_err.
//   It also increments by 1 on each overrun, at most +1 per clk.
//   It saturates at 2**CNT_W-1 and is reset to 0 by areset_n.
//   err_clr wins over an increment in the same clk.
//  Undefined: the ports and counter logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset, rx_bit=1 for 20 clk -> out_valid=0, overrun=0, outputs stay 0.
//  2. Send 0,1,1,0,1,1,1, out_ready=1 -> out_valid 1 clk after stop.
//     out_data=4'hB, out_and=0, out_or=1, par_err=0, frame_err=0.
//  3. Data 4'hF with par=1 (even) -> out_par_err=1, out_and=1, out_or=1.
//     Repeat with PARITY_ODD=1 -> par_err=0.
//  4. Data 4'h6, par=0, stop=0 -> out_frame_err=1, out_data=4'h6.
//     A back-to-back following frame 4'h1 is received cleanly.
//  5. out_ready=0, frames 4'h3 then 4'h5 back-to-back -> out_data holds 4'h3, overrun pulses 1 clk.
//     Raise out_ready -> 4'h3 accepted once, then out_valid=0.
//  6. areset_n=0 during data bit 2 -> all outputs 0 immediately. Release, send 4'hA -> out_data=4'hA.
//     ERRCNT_EN: after tests 3-5, err_count=3. err_clr -> 0. CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/nibble_parity_rx.sv
// nibble_parity_rx: serial deframer and checker for the framed nibble link.
// Frame on the line: start(0), DATA_W data bits LSB first, parity, stop(1).
// The completed word, its AND/OR reductions and its parity/framing flags are
// presented through a 1-deep registered valid/ready buffer.
// Optional feature macro: NIBBLE_PARITY_RX_ERRCNT_EN adds err_clr/err_count
// and the CNT_W parameter.
//
// Output handshake: a buffered frame transfers on any rising edge where
// out_valid && out_ready. out_valid and the payload are registered and never
// depend combinationally on out_ready or rx_bit. A frame that completes while
// the buffer is full and not being accepted is dropped and overrun pulses.
//
// dbg_state exposes the receive FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).

module nibble_parity_rx #(
    parameter int DATA_W     = 4,
    parameter bit PARITY_ODD = 1'b0
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    ,
    parameter int CNT_W      = 8
`endif
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              rx_bit,
    input  logic              out_ready,
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_and,
    output logic              out_or,
    output logic              out_par_err,
    output logic              out_frame_err,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q;
    logic              and_q, or_q, par_err_q, frame_err_q;
    logic              overrun_q;

    logic              complete_w;
    logic              par_err_w;
    logic              frame_err_w;
    logic              load_w;
    logic              drop_w;

    // The stop bit is sampled in STOP; that clock completes the frame.
    assign complete_w  = (state_q == ST_STOP);
    assign par_err_w   = (^shift_q) ^ par_q ^ PARITY_ODD;
    assign frame_err_w = ~rx_bit;
    assign load_w      = complete_w && (!valid_q || out_ready);
    assign drop_w      = complete_w && valid_q && !out_ready;

    // Receive FSM: one line sample per clock, no resync inside a frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_bit) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                shift_d[idx_q] = rx_bit;
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    state_d = ST_PARITY;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PARITY: begin
                par_d   = rx_bit;
                state_d = ST_STOP;
            end
            default: begin
                // A bad stop bit still ends the frame; the next clock may carry a start bit.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Receive state registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    // Buffer valid: set on load, cleared on accept with no new load.
    always_comb begin
        valid_d = valid_q;
        if (load_w) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output buffer: payload loads only on a completion that fits; otherwise holds.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            and_q       <= 1'b0;
            or_q        <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            overrun_q <= drop_w;
            if (load_w) begin
                data_q      <= shift_q;
                and_q       <= &shift_q;
                or_q        <= |shift_q;
                par_err_q   <= par_err_w;
                frame_err_q <= frame_err_w;
            end
        end
    end

`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc_w;

    // A bad completion and an overrun are the same clock at most once, so +1 max.
    assign cnt_inc_w = (complete_w && (par_err_w || frame_err_w)) || drop_w;

    // Saturating error counter; clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (cnt_inc_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`endif

    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_and       = and_q;
    assign out_or        = or_q;
    assign out_par_err   = par_err_q;
    assign out_frame_err = frame_err_q;
    assign overrun       = overrun_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_nibble_parity_rx.sv
// Directed bench for nibble_parity_rx: an even-parity instance and an
// odd-parity instance share the serial line and the consumer ready.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// NIBBLE_PARITY_RX_ERRCNT_EN also exercises the error counters.

module tb_nibble_parity_rx;

  logic       clk;
  logic       areset_n;
  logic       rx_bit;
  logic       out_ready;
  logic       err_clr;

  logic       out_valid, out_and, out_or, out_par_err, out_frame_err, overrun;
  logic [3:0] out_data;
  logic [1:0] dbg_state;

  logic       o_valid, o_and, o_or, o_par_err, o_frame_err, o_overrun;
  logic [3:0] o_data;
  logic [1:0] o_state;

`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
  logic [7:0] err_count;
  logic [1:0] o_err_count;
`endif

  int total;
  int bad;

  nibble_parity_rx #(
    .DATA_W(4),
    .PARITY_ODD(1'b0)
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    ,
    .CNT_W(8)
`endif
  ) u_dut (
    .clk(clk),
    .areset_n(areset_n),
    .rx_bit(rx_bit),
    .out_ready(out_ready),
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    .err_clr(err_clr),
    .err_count(err_count),
`endif
    .out_valid(out_valid),
    .out_data(out_data),
    .out_and(out_and),
    .out_or(out_or),
    .out_par_err(out_par_err),
    .out_frame_err(out_frame_err),
    .overrun(overrun),
    .dbg_state(dbg_state)
  );

  nibble_parity_rx #(
    .DATA_W(4),
    .PARITY_ODD(1'b1)
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    ,
    .CNT_W(2)
`endif
  ) u_dut_odd (
    .clk(clk),
    .areset_n(areset_n),
    .rx_bit(rx_bit),
    .out_ready(out_ready),
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    .err_clr(err_clr),
    .err_count(o_err_count),
`endif
    .out_valid(o_valid),
    .out_data(o_data),
    .out_and(o_and),
    .out_or(o_or),
    .out_par_err(o_par_err),
    .out_frame_err(o_frame_err),
    .overrun(o_overrun),
    .dbg_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic send_bit(input logic b);
    rx_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  // packed view: {valid, data, and, or, par_err, frame_err, overrun}
  function automatic logic [9:0] main_view();
    return {out_valid, out_data, out_and, out_or, out_par_err, out_frame_err, overrun};
  endfunction

  task automatic test_reset();
    areset_n  = 1'b0;
    rx_bit    = 1'b1;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (main_view() !== 10'h000 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs: got view=%h state=%0d, want view=000 state=0", main_view(), dbg_state);
    end
    areset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      total++;
      if (main_view() !== 10'h000 || dbg_state !== 2'd0) begin
        bad++;
        $display("FAIL idle_line[%0d]: got view=%h state=%0d, want view=000 state=0", i, main_view(), dbg_state);
      end
    end
  endtask

  task automatic test_basic();
    logic [6:0] bits;
    bits = 7'b1110110;  // line order 0,1,1,0,1,1,1 (bit 0 first)
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(bits[i]);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_before_stop: got valid=%b, want 0", out_valid);
    end
    send_bit(bits[6]);
    total++;
    if (main_view() !== {1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_frame_B: got view=%h, want %h", main_view(), {1'b1, 4'hB, 5'b01000});
    end
    send_bit(1'b1);
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'hB) begin
      bad++;
      $display("FAIL basic_accept: got valid=%b data=%h, want valid=0 data=b", out_valid, out_data);
    end
  endtask

  task automatic test_parity();
    out_ready = 1'b1;
    send_frame(4'hF, 1'b1, 1'b1);
    total++;
    if (main_view() !== {1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL parity_even_F: got view=%h, want %h", main_view(), {1'b1, 4'hF, 5'b11100});
    end
    total++;
    if (o_valid !== 1'b1 || o_data !== 4'hF || o_par_err !== 1'b0 || o_and !== 1'b1) begin
      bad++;
      $display("FAIL parity_odd_F: got valid=%b data=%h par_err=%b and=%b, want 1 f 0 1", o_valid, o_data, o_par_err, o_and);
    end
    send_bit(1'b1);
  endtask

  task automatic test_framing();
    out_ready = 1'b1;
    send_frame(4'h6, 1'b0, 1'b0);
    total++;
    if (main_view() !== {1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL frame_err_6: got view=%h, want %h", main_view(), {1'b1, 4'h6, 5'b01010});
    end
    send_frame(4'h1, 1'b1, 1'b1);
    total++;
    if (main_view() !== {1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL back_to_back_1: got view=%h, want %h", main_view(), {1'b1, 4'h1, 5'b01000});
    end
    send_bit(1'b1);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_first_load: got valid=%b data=%h ovr=%b, want 1 3 0", out_valid, out_data, overrun);
    end
    send_frame(4'h5, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_drop: got valid=%b data=%h ovr=%b, want 1 3 1", out_valid, out_data, overrun);
    end
    send_bit(1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_pulse_end: got valid=%b data=%h ovr=%b, want 1 3 0", out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    send_bit(1'b1);
    total++;
    if (out_valid !== 1'b0 || out_data !== 4'h3) begin
      bad++;
      $display("FAIL ovr_accept: got valid=%b data=%h, want 0 3", out_valid, out_data);
    end
    send_bit(1'b1);
    total++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_after_accept: got valid=%b ovr=%b, want 0 0", out_valid, overrun);
    end
  endtask

`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
  task automatic test_err_count();
    total++;
    if (err_count !== 8'd3) begin
      bad++;
      $display("FAIL errcnt_value: got %0d, want 3", err_count);
    end
    total++;
    if (o_err_count !== 2'd3) begin
      bad++;
      $display("FAIL errcnt_saturate: got %0d, want 3", o_err_count);
    end
    err_clr = 1'b1;
    send_bit(1'b1);
    err_clr = 1'b0;
    total++;
    if (err_count !== 8'd0 || o_err_count !== 2'd0) begin
      bad++;
      $display("FAIL errcnt_clear: got %0d/%0d, want 0/0", err_count, o_err_count);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    out_ready = 1'b0;
    send_frame(4'h9, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h9) begin
      bad++;
      $display("FAIL mid_preload: got valid=%b data=%h, want 1 9", out_valid, out_data);
    end
    send_bit(1'b0);  // start
    send_bit(1'b1);  // data bit 0
    send_bit(1'b0);  // data bit 1
    rx_bit   = 1'b0; // data bit 2 on the line
    areset_n = 1'b0;
    #1;
    total++;
    if (main_view() !== 10'h000 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL mid_async_reset: got view=%h state=%0d, want view=000 state=0", main_view(), dbg_state);
    end
    #2;
    areset_n  = 1'b1;
    out_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL mid_no_partial: got valid=%b state=%0d, want 0 0", out_valid, dbg_state);
    end
    send_frame(4'hA, 1'b0, 1'b1);
    total++;
    if (main_view() !== {1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_restart_A: got view=%h, want %h", main_view(), {1'b1, 4'hA, 5'b01000});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_overrun();
`ifdef NIBBLE_PARITY_RX_ERRCNT_EN
    test_err_count();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
